// File: rtl/j11cycle.sv
// DCJ11 pin-side bus cycle front end: synchronises ALE/SCTL/DAL/AIO, issues a
// one-cycle busreq, stretches the CPU with CONT_n and aborts on error/timeout.
module j11cycle #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [21:0] j11dal_i,
  output logic [15:0] j11dal_o,
  output logic        j11dal_oe,
  input  logic [3:0]  j11aio,
  input  logic        j11ale_n,
  input  logic        j11sctl_n,
  output logic        j11cont_n,
  output logic        j11abort_n,
  output logic        busreq,
  output logic        buswr,
  output logic        busgp,
  output logic        busirq,
  output logic [21:0] busaddr,
  output logic [15:0] buswdata,
  output logic [1:0]  buswstrb,
  input  logic        busack,
  input  logic        buserr,
  input  logic [15:0] busrdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic is_write(input logic [3:0] aio);
    return (aio == 4'b1101) || (aio == 4'b1100) || (aio == 4'b1110);
  endfunction

  function automatic logic is_gp(input logic [3:0] aio);
    return (aio == 4'b0000) || (aio == 4'b1101);
  endfunction

  function automatic logic [1:0] strobes(input logic wr, input logic byte_wr, input logic a0);
    if (!wr)      return 2'b00;
    if (!byte_wr) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  logic [21:0] dal_s1_q, dal_s2_q;
  logic [3:0]  aio_s1_q, aio_s2_q;
  logic        ale_s1_q, ale_s2_q, ale_p_q;
  logic        sctl_s1_q, sctl_s2_q, sctl_p_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             wr_q, wr_d, gp_q, gp_d, irq_q, irq_d, byte_q, byte_d;
  logic             busreq_q, busreq_d, buswr_q, buswr_d, busgp_q, busgp_d, busirq_q, busirq_d;
  logic [21:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d, dalo_q, dalo_d;
  logic [1:0]       strb_q, strb_d;
  logic             oe_q, oe_d, cont_q, cont_d, abort_q, abort_d;
  logic             ale_fall, sctl_fall;

  assign ale_fall  = ale_p_q & ~ale_s2_q;
  assign sctl_fall = sctl_p_q & ~sctl_s2_q;
  // The counter holds at TIMEOUT rather than wrapping back to zero.
  assign cnt_inc   = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    gp_d     = gp_q;
    irq_d    = irq_q;
    byte_d   = byte_q;
    busreq_d = 1'b0;
    buswr_d  = buswr_q;
    busgp_d  = busgp_q;
    busirq_d = busirq_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    dalo_d   = dalo_q;
    oe_d     = oe_q;
    cont_d   = cont_q;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: begin
        if (ale_fall && (aio_s2_q != 4'b1111)) begin
          addr_d  = dal_s2_q;
          wr_d    = is_write(aio_s2_q);
          gp_d    = is_gp(aio_s2_q);
          irq_d   = (aio_s2_q == 4'b0001);
          byte_d  = (aio_s2_q == 4'b1100);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (sctl_fall) begin
          if (wr_q) wdata_d = dal_s2_q[15:0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        busreq_d = 1'b1;
        buswr_d  = wr_q;
        busgp_d  = gp_q;
        busirq_d = irq_q;
        strb_d   = strobes(wr_q, byte_q, addr_q[0]);
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // An acknowledge in the same cycle as the timeout takes priority.
        if (busack) begin
          if (!wr_q) dalo_d = busrdata;
          cont_d  = 1'b0;
          abort_d = ~buserr;
          oe_d    = ~wr_q & ~buserr;
          state_d = S_DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          cont_d  = 1'b0;
          abort_d = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        if (sctl_s2_q) begin
          cont_d   = 1'b1;
          abort_d  = 1'b1;
          oe_d     = 1'b0;
          buswr_d  = 1'b0;
          busgp_d  = 1'b0;
          busirq_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dal_s1_q  <= '1;
      dal_s2_q  <= '1;
      aio_s1_q  <= '1;
      aio_s2_q  <= '1;
      ale_s1_q  <= 1'b1;
      ale_s2_q  <= 1'b1;
      ale_p_q   <= 1'b1;
      sctl_s1_q <= 1'b1;
      sctl_s2_q <= 1'b1;
      sctl_p_q  <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      gp_q      <= 1'b0;
      irq_q     <= 1'b0;
      byte_q    <= 1'b0;
      busreq_q  <= 1'b0;
      buswr_q   <= 1'b0;
      busgp_q   <= 1'b0;
      busirq_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      dalo_q    <= '0;
      oe_q      <= 1'b0;
      cont_q    <= 1'b1;
      abort_q   <= 1'b1;
    end else begin
      dal_s1_q  <= j11dal_i;
      dal_s2_q  <= dal_s1_q;
      aio_s1_q  <= j11aio;
      aio_s2_q  <= aio_s1_q;
      ale_s1_q  <= j11ale_n;
      ale_s2_q  <= ale_s1_q;
      ale_p_q   <= ale_s2_q;
      sctl_s1_q <= j11sctl_n;
      sctl_s2_q <= sctl_s1_q;
      sctl_p_q  <= sctl_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      gp_q      <= gp_d;
      irq_q     <= irq_d;
      byte_q    <= byte_d;
      busreq_q  <= busreq_d;
      buswr_q   <= buswr_d;
      busgp_q   <= busgp_d;
      busirq_q  <= busirq_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      dalo_q    <= dalo_d;
      oe_q      <= oe_d;
      cont_q    <= cont_d;
      abort_q   <= abort_d;
    end
  end

  assign busreq     = busreq_q;
  assign buswr      = buswr_q;
  assign busgp      = busgp_q;
  assign busirq     = busirq_q;
  assign busaddr    = addr_q;
  assign buswdata   = wdata_q;
  assign buswstrb   = strb_q;
  assign j11dal_o   = dalo_q;
  assign j11dal_oe  = oe_q;
  assign j11cont_n  = cont_q;
  assign j11abort_n = abort_q;

endmodule
